// File: rtl/mp_alu_pkg.sv
// Shared definitions for the byte-serial multi-precision ALU sequencer.
// Op-code encoding matches the 8-bit combinational ALU it drives.
package mp_alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_SUBA   = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_NAND_A = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;
    localparam logic [2:0] OP_XNOR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the add/subtract family propagates a carry between bytes.
    function automatic logic is_arith(input logic [2:0] oper);
        return (oper == OP_ADD) || (oper == OP_SUB) || (oper == OP_SUBA);
    endfunction

endpackage

// File: rtl/mp_alu_carry_sel.sv
// Purpose: selects the ALU carry-in for the current byte of a multi-byte op.
// Latency: combinational. Backpressure: none, pure decode.
module mp_alu_carry_sel
    import mp_alu_pkg::*;
(
    input  logic [2:0] oper,
    input  logic       first_byte,
    input  logic       req_cin,
    input  logic       carry,
    output logic       alu_cin
);

    always_comb begin
        alu_cin = 1'b0;
        case (oper)
            OP_ADD, OP_SUB: alu_cin = first_byte ? req_cin : carry;
            // The ALU inverts c_in for reverse subtract, so the chained carry is pre-inverted.
            OP_SUBA:        alu_cin = first_byte ? req_cin : ~carry;
            default:        alu_cin = 1'b0;
        endcase
    end

endmodule

// File: rtl/mp_alu_seq.sv
// Purpose: runs one NBYTES-wide op through the shared 8-bit ALU, LSB byte first; MP_ALU_ZFLAG_EN adds res_zero.
// Latency: request accepted at edge T, res_valid rises at edge T+NBYTES; one op per NBYTES+2 cycles.
// Backpressure: req_ready only in IDLE; result held stable in DONE until res_ready.
module mp_alu_seq
    import mp_alu_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_oper,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic [2:0]   alu_oper,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_cin,
    input  logic [7:0]   alu_sum,
    input  logic         alu_cout
`ifdef MP_ALU_ZFLAG_EN
    ,
    output logic         res_zero
`endif
);

    localparam int             IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     oper_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic [IW-1:0]  idx;
    logic           carry_q;
    logic           running;
    logic           last_byte;
    logic           accept;
    logic           cin_sel;

    assign running   = (state == RUN);
    assign last_byte = (idx == LAST_IDX);
    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign accept    = req_ready && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mp_alu_carry_sel u_carry_sel (
        .oper       (oper_q),
        .first_byte (idx == '0),
        .req_cin    (cin_q),
        .carry      (carry_q),
        .alu_cin    (cin_sel)
    );

    // ALU bus is parked at zero whenever no byte is being processed.
    always_comb begin
        alu_oper = 3'b000;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_cin  = 1'b0;
        if (running) begin
            alu_oper = oper_q;
            alu_a    = a_q[{idx, 3'b000} +: 8];
            alu_b    = b_q[{idx, 3'b000} +: 8];
            alu_cin  = cin_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oper_q   <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            idx      <= '0;
            carry_q  <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else if (accept) begin
            oper_q  <= req_oper;
            a_q     <= req_a;
            b_q     <= req_b;
            cin_q   <= req_cin;
            idx     <= '0;
            carry_q <= 1'b0;
        end else if (running) begin
            res_sum[{idx, 3'b000} +: 8] <= alu_sum;
            carry_q                     <= alu_cout;
            if (last_byte) begin
                idx      <= '0;
                res_cout <= is_arith(oper_q) & alu_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef MP_ALU_ZFLAG_EN
    // Lower bytes are already final when the top byte arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_zero <= 1'b0;
        end else if (running && last_byte) begin
            res_zero <= (alu_sum == 8'h00) && (res_sum[W-9:0] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mp_alu_seq.sv
// Scoreboarded random and directed bench for mp_alu_seq with a behavioural 8-bit ALU attached.
module tb_mp_alu_seq;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_oper;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic [2:0]   alu_oper;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [7:0]   alu_sum;
    logic         alu_cout;
`ifdef MP_ALU_ZFLAG_EN
    logic         res_zero;
`endif

    mp_alu_seq #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_oper  (req_oper),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .alu_oper  (alu_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout)
`ifdef MP_ALU_ZFLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External 8-bit ALU; logic ops return a junk carry the sequencer must mask.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'd0;
        case (alu_oper)
            3'b000: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            3'b001: alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            3'b010: alu_t = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'd0, ~alu_cin};
            3'b011: alu_t[7:0] = alu_a | alu_b;
            3'b100: alu_t[7:0] = alu_a & alu_b;
            3'b101: alu_t[7:0] = ~(alu_a & alu_b);
            3'b110: alu_t[7:0] = alu_a ^ alu_b;
            default: alu_t[7:0] = ~(alu_a ^ alu_b);
        endcase
        if (alu_oper > 3'b010) alu_t[8] = ^alu_t[7:0];
        alu_sum  = alu_t[7:0];
        alu_cout = alu_t[8];
    end

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        zero;
        logic [3:0]  cins;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rr_auto;
    bit   rr_force;

    // Word-level model: whole-word arithmetic, carries into each byte from partial sums.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin);
        exp_t        e;
        logic [63:0] x, y, c0, full, m, part;
        e.acc  = 0;
        e.cins = 4'b0000;
        e.cout = 1'b0;
        e.sum  = 32'd0;
        x = {32'd0, a};
        y = {32'd0, b};
        c0 = {63'd0, cin};
        if (op == 3'b001) y = {32'd0, ~b};
        if (op == 3'b010) begin
            x = {32'd0, b};
            y = {32'd0, ~a};
            c0 = {63'd0, ~cin};
        end
        if (op <= 3'b010) begin
            full   = x + y + c0;
            e.sum  = full[31:0];
            e.cout = full[32];
            for (int i = 0; i < 4; i++) begin
                m    = (64'd1 << (8 * i)) - 64'd1;
                part = ((x & m) + (y & m) + c0) >> (8 * i);
                e.cins[i] = (op == 3'b010) ? ~part[0] : part[0];
            end
        end else begin
            case (op)
                3'b011:  e.sum = a | b;
                3'b100:  e.sum = a & b;
                3'b101:  e.sum = ~(a & b);
                3'b110:  e.sum = a ^ b;
                default: e.sum = ~(a ^ b);
            endcase
        end
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        res_ready = rr_auto ? ($urandom_range(0, 3) != 0) : rr_force;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input exp_t e);
        logic r;
        bit   done;
        done      = 1'b0;
        req_oper  = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            r = req_ready;
            tick();
            if (r) done = 1'b1;
        end
        req_valid = 1'b0;
        chk("req_accept", {63'd0, done}, 64'd1);
        if (done) begin
            e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb_q.size() > 0; k++) tick();
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_res_sum"},   {32'd0, res_sum},   64'd0);
        chk({tag, "_res_cout"},  {63'd0, res_cout},  64'd0);
        chk({tag, "_alu_bus"},   {45'd0, alu_oper, alu_a, alu_b, alu_cin}, 64'd0);
`ifdef MP_ALU_ZFLAG_EN
        chk({tag, "_res_zero"},  {63'd0, res_zero},  64'd0);
`endif
    endtask

    // Monitor: logs carry-ins during RUN, checks latency/hold, pops scoreboard on handshake.
    logic        mon_pv;
    logic [31:0] mon_hs;
    logic        mon_hc;
    logic [3:0]  mon_rc;
    int          mon_rn;
    exp_t        mon_e;

    initial begin
        mon_pv = 1'b0;
        mon_hs = 32'd0;
        mon_hc = 1'b0;
        mon_rc = 4'd0;
        mon_rn = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pv = 1'b0;
                mon_rn = 0;
                mon_rc = 4'd0;
                continue;
            end
            if (!req_ready && !res_valid) begin
                if (mon_rn < 4) mon_rc[mon_rn] = alu_cin;
                mon_rn++;
            end
            if (res_valid && !mon_pv) begin
                chk("outstanding", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q[0];
                    chk("latency", 64'(cyc - mon_e.acc), N);
                    chk("run_cycles", 64'(mon_rn), N);
                    chk("alu_cin_seq", {60'd0, mon_rc}, {60'd0, mon_e.cins});
                end
                chk("alu_bus_idle", {45'd0, alu_oper, alu_a, alu_b, alu_cin}, 64'd0);
                mon_hs = res_sum;
                mon_hc = res_cout;
                mon_rn = 0;
                mon_rc = 4'd0;
            end else if (res_valid) begin
                chk("hold_sum", {32'd0, res_sum}, {32'd0, mon_hs});
                chk("hold_cout", {63'd0, res_cout}, {63'd0, mon_hc});
            end
            if (res_valid && res_ready && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("res_sum", {32'd0, res_sum}, {32'd0, mon_e.sum});
                chk("res_cout", {63'd0, res_cout}, {63'd0, mon_e.cout});
`ifdef MP_ALU_ZFLAG_EN
                chk("res_zero", {63'd0, res_zero}, {63'd0, mon_e.zero});
`endif
            end
            mon_pv = res_valid;
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        cin;
        int          mode;
        bit          seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_oper  = 3'b000;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        res_ready = 1'b1;
        rr_auto   = 1'b0;
        rr_force  = 1'b1;
        #3;
        chk_reset_outputs("por");
        tick();
        tick();
        rst     = 1'b0;
        rr_auto = 1'b1;
        tick();

        // Directed cases with hand-derived expectations.
        issue(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 4'b0010, 0});
        issue(3'b001, 32'h0000_0000, 32'h0000_0001, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0001, 0});
        issue(3'b010, 32'h0000_0001, 32'h0001_0000, 1'b0, '{32'h0000_FFFF, 1'b1, 1'b0, 4'b0110, 0});
        issue(3'b110, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, '{32'h0F0F_F0F0, 1'b0, 1'b0, 4'b0000, 0});
        issue(3'b110, 32'h1234_5678, 32'h1234_5678, 1'b0, '{32'h0000_0000, 1'b0, 1'b1, 4'b0000, 0});
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b1, 4'b1111, 0});
        drain();

        // Backpressure: result held in DONE while requests are offered.
        rr_auto  = 1'b0;
        rr_force = 1'b0;
        tick();
        issue(3'b000, 32'h89AB_CDEF, 32'h7654_3211, 1'b0, ref_model(3'b000, 32'h89AB_CDEF, 32'h7654_3211, 1'b0));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (res_valid) seen = 1'b1;
            else tick();
        end
        chk("bp_res_valid_wait", {63'd0, seen}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            req_valid = k[0];
            req_oper  = 3'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = $urandom;
            tick();
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
        end
        req_valid = 1'b0;
        rr_force  = 1'b1;
        tick();
        tick();
        chk("bp_release_valid", {63'd0, res_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
        rr_auto = 1'b1;
        tick();
        tick();
        chk("bp_no_capture", {63'd0, req_ready}, 64'd1);

        // Asynchronous reset while the third byte is on the ALU.
        issue(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 4'b0010, 0});
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun");
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rst_valid", {63'd0, res_valid}, 64'd0);
        issue(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 4'b0010, 0});
        drain();

        // Random traffic with biased operand patterns.
        for (int n = 0; n < 150; n++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            cin  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 7);
            if (mode == 0) b = a;
            if (mode == 1) begin a = 32'd0; b = 32'd0; end
            if (mode == 2) b = ~a;
            issue(op, a, b, cin, ref_model(op, a, b, cin));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp_alu_seq.md
Name: mp_alu_seq

Overview:
Byte-serial multi-precision sequencer for the team's 8-bit combinational ALU (3-bit oper, 8-bit a/b/sum, c_in/c_out).
- Accepts one NBYTES-wide operation over a valid/ready request channel.
- Drives the external ALU one byte per cycle, LSB first, chaining carries.
- Returns the full-width result on a valid/ready response channel.
- Sits between a requesting controller and one shared ALU instance.

Parameters:
NBYTES, 4, operand width in bytes (>=2); word width W = 8*NBYTES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_oper  in  3  ALU op code, same encoding as the ALU
req_a  in  W  operand A
req_b  in  W  operand B
req_cin  in  1  carry-in for the whole word
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_sum  out  W  result word
res_cout  out  1  final carry-out (0 for logic ops)
alu_oper  out  3  to ALU oper
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_cin  out  1  to ALU c_in
alu_sum  in  8  from ALU sum, combinational same cycle
alu_cout  in  1  from ALU c_out, combinational same cycle

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, res_valid=0, res_sum=0, res_cout=0, alu_oper=000, alu_a=0, alu_b=0, alu_cin=0, byte index=0, carry reg=0.
- Reset mid-operation discards the operation; no partial result is ever presented.
- All outputs are registered or decoded from state; no combinational path from req_* to res_*.

States:
- IDLE: req_ready=1. On req_valid: capture oper/a/b/cin, idx<=0, go RUN.
- RUN: req_ready=0.
  - Drive alu_oper=oper, alu_a=a[8*idx+:8], alu_b=b[8*idx+:8].
  - On each clock: res_sum byte idx <= alu_sum, carry reg <= alu_cout, idx<=idx+1.
  - At idx==NBYTES-1: go DONE; res_cout <= alu_cout for ops 000/001/010, else 0.
- DONE: res_valid=1, req_ready=0. On res_ready: res_valid<=0, go IDLE. res_sum and res_cout hold stable while res_valid=1 and res_ready=0.

Timing:
- Latency: request accepted at edge T; RUN occupies NBYTES cycles; res_valid rises at edge T+NBYTES.
- Throughput: at most one operation per NBYTES+2 cycles.
- No new request is accepted in the same cycle as a result handshake.

Carry chaining (alu_cin during RUN):
- oper 000/001: byte0 = req_cin; byte i>0 = carry reg.
- oper 010: the ALU inverts c_in internally, so byte0 = req_cin; byte i>0 = ~carry reg.
- oper 011..111: alu_cin=0 every byte.

Outside RUN: alu_* outputs hold their reset values.

Optional Feature:
MP_ALU_ZFLAG_EN
- Defined: adds output port res_zero (1 bit), registered, valid with res_valid; it is 1 iff res_sum==0 for every op. Reset value 0.
- Undefined: port absent; no other behaviour change.

Decomposition:
- Package mp_alu_pkg holds:
  - op-code constants OP_ADD=000, OP_SUB=001, OP_SUBA=010, OP_OR=011, OP_AND=100, OP_NAND_A=101, OP_XOR=110, OP_XNOR=111;
  - state encoding IDLE/RUN/DONE;
  - helper is_arith(oper).
- One sub-module: mp_alu_carry_sel. It is combinational and maps (oper, first_byte, req_cin, carry reg) to alu_cin.
- The byte mux and result assembly stay in the top module.

Test Plan:
- NBYTES=4, add: oper=000, a=0x000000FF, b=0x00000001, cin=0.
  -> res_sum=0x00000100, res_cout=0.
  -> res_valid exactly 4 cycles after acceptance edge.
- Subtract: oper=001, a=0x00000000, b=0x00000001, cin=1.
  -> res_sum=0xFFFFFFFF, res_cout=0.
  -> alu_cin sequence per byte = 1,0,0,0.
- Reverse subtract: oper=010, a=0x00000001, b=0x00010000, cin=0.
  -> res_sum=0x0000FFFF, res_cout=1.
  -> alu_cin sequence = 0,1,1,0.
- XOR: oper=110, a=0xF0F0F0F0, b=0xFFFF0000.
  -> res_sum=0x0F0FF0F0, res_cout=0, alu_cin=0 all bytes.
  -> with MP_ALU_ZFLAG_EN, res_zero=0; a=b gives res_zero=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE while pulsing req_valid.
  -> res_valid, res_sum, res_cout stable; req_ready=0; no request captured.
  -> res_ready=1 returns to IDLE next edge.
- Reset asserted during RUN at idx=2.
  -> outputs take reset values without waiting for a clock edge.
  -> after deassert, req_ready=1, res_valid=0.
  -> a fresh add completes correctly.
